// File: rtl/tick_gen_multi.sv
// tick_gen_multi: multi-channel programmable tick generator on the 1 ms time base.
// Each channel divides clk_1ms by a runtime-loadable period, periodic or one-shot.
// A registered tick follows P edges after a load. Global pause freezes counters and suppresses ticks.
//
// Ports:
//   clk_1ms  : 1 ms clock, all logic on its rising edge
//   reset    : synchronous, active-high
//   en       : per-channel enable; low clears the counter, keeps period and arm state
//   oneshot  : per-channel mode (1 = one-shot, 0 = periodic), sampled every cycle
//   period   : per-channel period, channel i at [i*CNT_W +: CNT_W]
//   load     : per-channel load/arm strobe
//   pause    : global freeze
//   tick     : registered one-cycle tick pulses
//   busy     : one-shot armed and not yet fired
//   tick_cnt : per-channel 8-bit tick event counts, channel i at [i*8 +: 8]
//
// Build option: define TICK_GEN_TICKCNT_EN to include the per-channel tick event
// counters. Without it, tick_cnt is tied to zero.

module tick_gen_multi #(
  parameter int CHANNELS       = 4,
  parameter int CNT_W          = 10,
  parameter int DEFAULT_PERIOD = 5
) (
  input  logic                      clk_1ms,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       oneshot,
  input  logic [CHANNELS*CNT_W-1:0] period,
  input  logic [CHANNELS-1:0]       load,
  input  logic                      pause,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*8-1:0]     tick_cnt
);

  logic [CNT_W-1:0]    per_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt     [CHANNELS];
  logic [CNT_W-1:0]    per_nxt [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] tick_nxt;
  logic [CHANNELS-1:0] busy_nxt;

  // Next-state per channel, in priority order: load, !en, pause, count.
  always_comb begin
    tick_nxt = '0;
    busy_nxt = busy;
    for (int i = 0; i < CHANNELS; i++) begin
      per_nxt[i] = per_q[i];
      cnt_nxt[i] = cnt[i];
      if (load[i]) begin
        per_nxt[i]  = period[i*CNT_W +: CNT_W];
        cnt_nxt[i]  = '0;
        busy_nxt[i] = oneshot[i];
      end else if (!en[i]) begin
        // Arm state survives disable, so an armed one-shot restarts from zero.
        cnt_nxt[i] = '0;
      end else if (pause) begin
        cnt_nxt[i] = cnt[i];
      end else if (oneshot[i] && !busy[i]) begin
        // Un-armed one-shot idles.
        cnt_nxt[i] = '0;
      end else if (per_q[i] == '0) begin
        // Zero period parks the channel.
        cnt_nxt[i] = '0;
      end else if (cnt[i] == per_q[i] - CNT_W'(1)) begin
        cnt_nxt[i]  = '0;
        tick_nxt[i] = 1'b1;
        if (oneshot[i]) begin
          busy_nxt[i] = 1'b0;
        end
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_1ms) begin
    if (reset) begin
      tick <= '0;
      busy <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        per_q[i] <= CNT_W'(DEFAULT_PERIOD);
        cnt[i]   <= '0;
      end
    end else begin
      tick <= tick_nxt;
      busy <= busy_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        per_q[i] <= per_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

`ifdef TICK_GEN_TICKCNT_EN
  logic [7:0] tcnt [CHANNELS];

  // Counts every edge that drives tick high; wraps naturally at 8 bits.
  always_ff @(posedge clk_1ms) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset || load[i]) begin
        tcnt[i] <= '0;
      end else if (tick_nxt[i]) begin
        tcnt[i] <= tcnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    tick_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      tick_cnt[i*8 +: 8] = tcnt[i];
    end
  end
`else
  assign tick_cnt = '0;
`endif

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: reset defaults, load/period, one-shot,
// pause/enable, load-on-terminal collision, reset mid-count, and tick_cnt.
module tb_tick_gen_multi;

  localparam int CH = 4;
  localparam int CW = 10;

  logic            clk_1ms = 1'b0;
  logic            reset;
  logic [CH-1:0]   en;
  logic [CH-1:0]   oneshot;
  logic [CH*CW-1:0] period;
  logic [CH-1:0]   load;
  logic            pause;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   busy;
  logic [CH*8-1:0] tick_cnt;

  int checks = 0;
  int errors = 0;

  tick_gen_multi #(.CHANNELS(CH), .CNT_W(CW), .DEFAULT_PERIOD(5)) dut (
    .clk_1ms  (clk_1ms),
    .reset    (reset),
    .en       (en),
    .oneshot  (oneshot),
    .period   (period),
    .load     (load),
    .pause    (pause),
    .tick     (tick),
    .busy     (busy),
    .tick_cnt (tick_cnt)
  );

  always #5 clk_1ms = ~clk_1ms;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n edges; sampling and driving happen 1 time unit after the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_1ms);
    #1;
  endtask

  task automatic set_period(input int ch, input int p);
    period[ch*CW +: CW] = CW'(p);
  endtask

  // Pulse load on the given channels for one edge.
  task automatic do_load(input logic [CH-1:0] m);
    load = m;
    cyc(1);
    load = '0;
  endtask

  logic [7:0] exp_tc;

  initial begin
    reset = 1'b1; en = 4'b0001; oneshot = '0; period = '0; load = '0; pause = 1'b0;

    // Reset default: ch0 ticks every 5 cycles, first after the 5th edge.
    cyc(1);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tcnt", tick_cnt, 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      check("dflt_tick", 32'(tick), (k % 5 == 0) ? 32'h1 : 32'h0);
    end

    // Period 3 on ch1.
    en = 4'b0010;
    set_period(1, 3);
    do_load(4'b0010);
    check("p3_load", 32'(tick[1]), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      check("p3_tick", 32'(tick[1]), (k % 3 == 0) ? 32'h1 : 32'h0);
    end
    // Period 1: tick continuously high.
    set_period(1, 1);
    do_load(4'b0010);
    check("p1_load", 32'(tick[1]), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      check("p1_tick", 32'(tick[1]), 32'h1);
    end
    // Period 0: no ticks.
    set_period(1, 0);
    do_load(4'b0010);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      check("p0_tick", 32'(tick[1]), 32'h0);
    end

    // One-shot on ch2, period 4.
    en = 4'b0100; oneshot = 4'b0100;
    set_period(2, 4);
    do_load(4'b0100);
    check("os_busy0", 32'(busy), 32'h4);
    check("os_tick0", 32'(tick), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      check("os_busy", 32'(busy), 32'h4);
      check("os_tick", 32'(tick), 32'h0);
    end
    cyc(1);
    check("os_fire_tick", 32'(tick), 32'h4);
    check("os_fire_busy", 32'(busy), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      check("os_after", 32'(tick), 32'h0);
    end

    // Pause 3 cycles at cnt=2 delays the tick by 3.
    en = 4'b0001; oneshot = '0;
    set_period(0, 5);
    do_load(4'b0001);
    cyc(2);
    check("pz_pre", 32'(tick[0]), 32'h0);
    pause = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      check("pz_hold", 32'(tick[0]), 32'h0);
    end
    pause = 1'b0;
    cyc(2);
    check("pz_early", 32'(tick[0]), 32'h0);
    cyc(1);
    check("pz_tick", 32'(tick[0]), 32'h1);

    // Drop en at cnt=2, re-enable: tick 5 edges later.
    cyc(2);
    en = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      check("dis_tick", 32'(tick[0]), 32'h0);
    end
    en = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      check("reen_wait", 32'(tick[0]), 32'h0);
    end
    cyc(1);
    check("reen_tick", 32'(tick[0]), 32'h1);

    // Load ch3 on its terminal-count cycle: no tick, restart.
    en = 4'b1000;
    set_period(3, 3);
    do_load(4'b1000);
    cyc(2);
    check("col_pre", 32'(tick[3]), 32'h0);
    do_load(4'b1000);
    check("col_none", 32'(tick[3]), 32'h0);
    cyc(2);
    check("col_wait", 32'(tick[3]), 32'h0);
    cyc(1);
    check("col_tick", 32'(tick[3]), 32'h1);

    // Reset mid-count: outputs clear, periods revert to 5.
    en = 4'b1100; oneshot = 4'b0100;
    set_period(2, 10);
    set_period(3, 7);
    do_load(4'b1100);
    cyc(2);
    check("mid_busy", 32'(busy), 32'h4);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("mrst_tick", 32'(tick), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    en = 4'b1001; oneshot = '0;
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      check("mrst_per", 32'(tick), (k == 5) ? 32'h9 : 32'h0);
    end

    // tick_cnt: period 1 for 260 cycles wraps to 4, load clears it.
    en = 4'b0001;
    set_period(0, 1);
    do_load(4'b0001);
    check("tc_load", 32'(tick_cnt[7:0]), 32'h0);
    cyc(260);
`ifdef TICK_GEN_TICKCNT_EN
    exp_tc = 8'd4;
`else
    exp_tc = 8'd0;
`endif
    check("tc_wrap", 32'(tick_cnt[7:0]), 32'(exp_tc));
    check("tc_others", 32'(tick_cnt[31:8]), 32'h0);
    do_load(4'b0001);
    check("tc_clear", 32'(tick_cnt[7:0]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_gen_multi.md
# tick_gen_multi

Multi-channel programmable tick generator driven by the 1 ms game time base. Each channel divides `clk_1ms` by its own runtime-loadable period and emits single-cycle tick pulses, either free-running (periodic) or once per arm (one-shot). It replaces single fixed-ratio dividers, feeding game logic such as animation steps, enemy movement, display refresh and timeouts, with a global pause for game-freeze.

## Interface
- `CHANNELS`, 4: number of independent channels.
- `CNT_W`, 10: period/counter width in bits (max period 2^CNT_W − 1 ms).
- `DEFAULT_PERIOD`, 5: period loaded into every channel at reset.

Ports:
- `clk_1ms`  in  1  1 ms clock. All logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `en`  in  CHANNELS  per-channel enable.
- `oneshot`  in  CHANNELS  per-channel mode. 1 = one-shot, 0 = periodic. Sampled every cycle.
- `period`  in  CHANNELS*CNT_W  per-channel period. Channel i occupies bits [i*CNT_W +: CNT_W].
- `load`  in  CHANNELS  per-channel load/arm strobe, one cycle.
- `pause`  in  1  global freeze.
- `tick`  out  CHANNELS  registered one-cycle tick pulses.
- `busy`  out  CHANNELS  one-shot armed and not yet fired.
- `tick_cnt`  out  CHANNELS*8  per-channel tick event counts (see Configuration).

## Operation
- Per-channel state:
  - `per_q` (CNT_W): latched period.
  - `cnt` (CNT_W): cycle counter.
  - `tick` and `busy` registers.
- Reset: `per_q` = DEFAULT_PERIOD, `cnt` = 0, `tick` = 0, `busy` = 0, `tick_cnt` = 0 for all channels.
- Per-channel priority at each edge, highest first:
  1. reset
  2. load
  3. !en
  4. pause
  5. count
- Load:
  - `per_q` ← `period` slice; `cnt` ← 0; `tick` ← 0.
  - `busy` ← 1 if `oneshot`=1, else `busy` ← 0.
- !en: `cnt` ← 0, `tick` ← 0. `busy` and `per_q` hold, so an armed one-shot restarts from 0 when re-enabled.
- pause: `cnt` holds, `tick` ← 0, `busy` holds.
- Count is active when periodic, or when one-shot with `busy`=1:
  - If `cnt` == `per_q` − 1: `cnt` ← 0, `tick` ← 1; in one-shot mode, `busy` ← 0.
  - Otherwise: `cnt` ← `cnt` + 1, `tick` ← 0.
- A one-shot channel with `busy`=0 is idle: `cnt` = 0, `tick` = 0.
- `per_q` = 0 disables the channel: `cnt` stays 0, no ticks, `busy` holds.
- `per_q` = 1: in periodic mode, `tick` is high every cycle.
- The terminal compare is exact equality. Counter arithmetic is CNT_W-bit, and `cnt` never exceeds `per_q` − 1 because load always clears it.
- Changing the `oneshot` input while a channel is running takes effect at the next edge. An un-armed one-shot channel then idles.

## Timing
- Latency: after a load at edge E (channel enabled, not paused), the first `tick` is high in the cycle following edge E+P, where P = `per_q`. Subsequent ticks follow every P cycles.
- `tick` is a registered output, high for exactly one cycle per terminal count (except P=1 periodic, where it is continuously high).
- Load and terminal count in the same cycle: load wins, no tick, and the count restarts.
- Pause cycles extend the period 1:1. The next tick arrives exactly (pause cycles) later.
- Reset asserted mid-count: all outputs are 0 after that edge, and `per_q` reverts to DEFAULT_PERIOD.
- Channels are fully independent. Only `pause` and `reset` are shared.

## Configuration
- Macro `TICK_GEN_TICKCNT_EN`.
- Defined:
  - Each channel keeps an 8-bit counter that increments on every cycle its `tick` is driven high.
  - It wraps 255 → 0 and is cleared by reset or that channel's load.
  - `tick_cnt[i*8 +: 8]` reports it.
- Not defined: `tick_cnt` is tied to 0 and no counter logic is synthesised. All other behaviour is identical.

## Test plan
- Reset default:
  - Stimulus: reset 1 cycle, then `en`=4'b0001, periodic, no load.
  - Response: ch0 `tick` pulses every 5 cycles, the first in the cycle after the 5th edge post-reset. Other channels `tick`=0.
- Load/period:
  - Stimulus: load ch1 with period 3, periodic, enabled.
  - Response: ticks 3 cycles apart. Loading period 1 gives `tick` constantly high. Loading period 0 gives no ticks.
- One-shot:
  - Stimulus: ch2 `oneshot`=1, load period 4.
  - Response: `busy`=1 for 4 cycles, then one `tick` pulse with `busy`→0 on the same edge. No further ticks until the next load.
- Pause/enable:
  - Stimulus: ch0 period 5, pause asserted for 3 cycles at `cnt`=2.
  - Response: the tick is delayed exactly 3 cycles.
  - Stimulus: drop `en` at `cnt`=2.
  - Response: `cnt` clears, and re-enable yields a tick 5 cycles later.
- Collision/reset:
  - Stimulus: load ch3 on its terminal-count cycle.
  - Response: no tick; the next tick arrives P cycles later.
  - Stimulus: reset mid-count.
  - Response: `tick`/`busy` 0 and period back to 5.
- Macro on:
  - Stimulus: ch0 period 1 for 260 cycles.
  - Response: `tick_cnt` wraps and reads 4. A load clears it to 0.
  - Macro off: `tick_cnt` = 0 throughout.
